// File: rtl/hilbert_mac_seq.sv
// Hilbert-transform FIR, one shared 16x16 MAC per clock.
// Each accepted sample goes into a circular history buffer. The filter then
// walks the taps from the newest sample backwards, one product per cycle, and
// emits one truncated result. A one-entry pending slot absorbs a single sample
// that arrives while the MAC is busy. Further early samples are dropped and
// flagged in the sticky overrun bit.
module hilbert_mac_seq #(
  parameter int                 N_TAPS = 31,
  parameter logic signed [15:0] COEFFS [N_TAPS] = '{
    -16'sd523,  16'sd0, -16'sd427,  16'sd0, -16'sd612,  16'sd0, -16'sd870,   16'sd0,
    -16'sd1257, 16'sd0, -16'sd1915, 16'sd0, -16'sd3372, 16'sd0, -16'sd10396, 16'sd0,
     16'sd10396, 16'sd0, 16'sd3372, 16'sd0,  16'sd1915, 16'sd0,  16'sd1257,  16'sd0,
     16'sd870,  16'sd0,  16'sd612,  16'sd0,  16'sd427,  16'sd0,  16'sd523
  },
  parameter int                 SHIFT  = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pcm_valid,
  input  logic signed [15:0] din,
  output logic signed [15:0] dout,
  output logic               out_valid,
  output logic               busy,
  output logic               overrun,
  input  logic               clr_overrun
);

  localparam int PW = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam logic [PW-1:0] LAST = PW'(N_TAPS - 1);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                    state_q;
  logic signed [15:0]        hist_q [N_TAPS];
  logic        [PW-1:0]      wr_ptr_q;
  logic        [PW-1:0]      rd_ptr_q;   // (newest - k) mod N_TAPS
  logic        [PW-1:0]      k_q;
  logic signed [39:0]        acc_q;
  logic                      pend_valid_q;
  logic signed [15:0]        pend_data_q;
  logic signed [15:0]        dout_q;
  logic                      out_valid_q;
  logic                      overrun_q;

  logic                      take_pend;
  logic                      take_din;
  logic                      capture;
  logic                      drop;
  logic signed [15:0]        sample;
  logic                      pend_valid_d;
  logic signed [15:0]        pend_data_d;
  logic                      overrun_d;
  logic signed [31:0]        prod;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
    return (p == '0) ? LAST : p - 1'b1;
  endfunction

  // Single shared multiplier: current history tap times current coefficient.
  assign prod = 32'(hist_q[rd_ptr_q]) * 32'(COEFFS[k_q]);

  // Sample arbitration: pending beats a fresh strobe in IDLE; a strobe not
  // consumed directly goes to pending if the slot is (or becomes) free.
  always_comb begin
    take_pend = 1'b0;
    take_din  = 1'b0;
    if (state_q == IDLE) begin
      take_pend = pend_valid_q;
      take_din  = !pend_valid_q && pcm_valid;
    end
    capture = pcm_valid && !take_din && (!pend_valid_q || take_pend);
    drop    = pcm_valid && !take_din && pend_valid_q && !take_pend;
    sample  = take_pend ? pend_data_q : din;

    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    if (capture) begin
      pend_valid_d = 1'b1;
      pend_data_d  = din;
    end else if (take_pend) begin
      pend_valid_d = 1'b0;
    end

    // A drop on the same edge as a clear keeps the flag set.
    overrun_d = overrun_q;
    if (drop)             overrun_d = 1'b1;
    else if (clr_overrun) overrun_d = 1'b0;
  end

  // Pending slot and sticky overrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      overrun_q    <= 1'b0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      overrun_q    <= overrun_d;
    end
  end

  // Control FSM with datapath: IDLE accepts, MAC walks taps, DONE publishes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      for (int i = 0; i < N_TAPS; i++) hist_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (take_pend || take_din) begin
            hist_q[wr_ptr_q] <= sample;
            rd_ptr_q         <= wr_ptr_q;
            wr_ptr_q         <= ptr_inc(wr_ptr_q);
            acc_q            <= '0;
            k_q              <= '0;
            state_q          <= MAC;
          end
        end
        MAC: begin
          acc_q    <= acc_q + 40'(prod);
          rd_ptr_q <= ptr_dec(rd_ptr_q);
          if (k_q == LAST) begin
            state_q <= DONE;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        DONE: begin
          dout_q      <= acc_q[SHIFT+15:SHIFT];
          out_valid_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dout      = dout_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;

endmodule
